// File: rtl/rand_pkg.sv
// rand_pkg: shared state type and constant helpers for rand_range_pick.
package rand_pkg;

    localparam int DATA_W = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        SAMPLE = 1'b1
    } state_t;

    // Smallest k with 2**k >= n, valid for n in 1..256.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i <= DATA_W; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Rejection mask: all ones up to the next power of two covering n (0 for n = 1).
    function automatic logic [DATA_W-1:0] mask_of(input int n);
        return DATA_W'((1 << clog2(n)) - 1);
    endfunction

endpackage

// File: rtl/rand_range_fold.sv
// rand_range_fold: fallback value for a masked sample that never got accepted.
// Folds m (always < 2*RANGE) back into range, then bumps it by one (wrapping)
// when it would repeat the previous output and the repeat guard is armed.
module rand_range_fold
    import rand_pkg::*;
#(
    parameter int RANGE = 10
) (
    input  logic [DATA_W-1:0] m,
    input  logic [DATA_W-1:0] last,
    input  logic              last_ok,
    output logic [DATA_W-1:0] fb_value
);

    localparam logic [DATA_W:0]   RANGE_EXT = RANGE[DATA_W:0];
    localparam logic [DATA_W-1:0] RANGE_LO  = RANGE[DATA_W-1:0];
    localparam logic [DATA_W-1:0] RANGE_TOP = DATA_W'(RANGE - 1);

    logic [DATA_W-1:0] w_fold;
    logic [DATA_W-1:0] w_bump;
    logic              w_hit;

    // RANGE = 256 never folds: the 9-bit compare is false for every byte.
    assign w_fold   = ({1'b0, m} >= RANGE_EXT) ? (m - RANGE_LO) : m;
    assign w_bump   = (w_fold == RANGE_TOP) ? '0 : (w_fold + 1'b1);
    assign w_hit    = last_ok && (RANGE > 1) && (w_fold == last);
    assign fb_value = w_hit ? w_bump : w_fold;

endmodule

// File: rtl/rand_range_pick.sv
// rand_range_pick: turns the free-running LFSR byte into a uniform value in
// [0, RANGE-1] by masked rejection sampling with at most MAX_TRIES samples,
// then a deterministic fold fallback. Result is a one-cycle valid pulse with
// a held value/fallback pair.
// Optional feature macro: RAND_NO_REPEAT_EN (reject/bump a repeat of the last value).
module rand_range_pick
    import rand_pkg::*;
#(
    parameter int RANGE     = 10,
    parameter int MAX_TRIES = 15
) (
    input  logic              clk_25M,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] rand_num,
    input  logic              req,
    output logic              busy,
    output logic              valid,
    output logic [DATA_W-1:0] value,
    output logic              fallback
);

    localparam logic [DATA_W-1:0] MASK      = mask_of(RANGE);
    localparam logic [DATA_W:0]   RANGE_EXT = RANGE[DATA_W:0];
    localparam logic [DATA_W-1:0] LAST_TRY  = DATA_W'(MAX_TRIES - 1);

    state_t            r_state, w_state_nxt;
    logic [DATA_W-1:0] r_tries, w_tries_nxt;
    logic              r_valid, w_valid_nxt;
    logic [DATA_W-1:0] r_value, w_value_nxt;
    logic              r_fallback, w_fallback_nxt;

    logic [DATA_W-1:0] w_m;
    logic              w_in_range;
    logic              w_repeat;
    logic [DATA_W-1:0] w_last;
    logic              w_last_ok;
    logic [DATA_W-1:0] w_fb_value;

    // The raw byte is used unregistered: a fresh sample is evaluated every edge.
    assign w_m        = rand_num & MASK;
    assign w_in_range = {1'b0, w_m} < RANGE_EXT;

`ifdef RAND_NO_REPEAT_EN
    logic [DATA_W-1:0] r_last;
    logic              r_last_ok;

    assign w_last    = r_last;
    assign w_last_ok = r_last_ok;
    assign w_repeat  = r_last_ok && (RANGE > 1) && (w_m == r_last);

    // Remember every produced value so the next request can avoid repeating it.
    always_ff @(posedge clk_25M or negedge rst_n) begin
        if (!rst_n) begin
            r_last    <= '0;
            r_last_ok <= 1'b0;
        end else if (w_valid_nxt) begin
            r_last    <= w_value_nxt;
            r_last_ok <= 1'b1;
        end
    end
`else
    assign w_last    = '0;
    assign w_last_ok = 1'b0;
    assign w_repeat  = 1'b0;
`endif

    rand_range_fold #(
        .RANGE (RANGE)
    ) u_fold (
        .m        (w_m),
        .last     (w_last),
        .last_ok  (w_last_ok),
        .fb_value (w_fb_value)
    );

    // Next state, retry count and output-register updates.
    always_comb begin
        // NOTE: every signal gets a default first, so no branch can leave one unassigned and infer a latch.
        w_state_nxt    = r_state;
        w_tries_nxt    = r_tries;
        w_valid_nxt    = 1'b0;
        w_value_nxt    = r_value;
        w_fallback_nxt = r_fallback;
        case (r_state)
            IDLE: begin
                if (req) begin
                    w_state_nxt = SAMPLE;
                    w_tries_nxt = '0;
                end
            end
            SAMPLE: begin
                if (w_in_range && !w_repeat) begin
                    w_state_nxt    = IDLE;
                    w_valid_nxt    = 1'b1;
                    w_value_nxt    = w_m;
                    w_fallback_nxt = 1'b0;
                end else if (r_tries == LAST_TRY) begin
                    w_state_nxt    = IDLE;
                    w_valid_nxt    = 1'b1;
                    w_value_nxt    = w_fb_value;
                    w_fallback_nxt = 1'b1;
                end else begin
                    w_tries_nxt = r_tries + 1'b1;
                end
            end
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clk_25M or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: value/fallback are reset too: they are visible outputs that consumers may read before the first valid.
            r_state    <= IDLE;
            r_tries    <= '0;
            r_valid    <= 1'b0;
            r_value    <= '0;
            r_fallback <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register see pre-edge values, independent of statement order.
            r_state    <= w_state_nxt;
            r_tries    <= w_tries_nxt;
            r_valid    <= w_valid_nxt;
            r_value    <= w_value_nxt;
            r_fallback <= w_fallback_nxt;
        end
    end

    assign busy     = (r_state == SAMPLE);
    assign valid    = r_valid;
    assign value    = r_value;
    assign fallback = r_fallback;

endmodule

// File: tb/tb_rand_range_pick.sv
// tb_rand_range_pick: scoreboard bench for rand_range_pick. Four instances
// (RANGE/MAX_TRIES = 10/15, 10/4, 1/15, 256/15) share clock, reset and the
// random byte; requests go to one instance at a time. The driver computes
// each expected result from the picking rules and queues it; a monitor pops
// on every valid pulse and also checks that value/fallback hold in between.
module tb_rand_range_pick;

    localparam int N_DUT = 4;

    typedef logic [7:0] byte_q_t[$];

    typedef struct {
        int         idx;
        logic [7:0] value;
        logic       fb;
        int         cyc;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] rand_num;
    logic [3:0] req;
    logic [3:0] busy;
    logic [3:0] valid;
    logic [3:0] fallback;
    logic [7:0] value [N_DUT];

    int ranges [N_DUT] = '{10, 10, 1, 256};
    int tries  [N_DUT] = '{15, 4, 15, 15};

    int         model_last    [N_DUT];
    bit         model_last_ok [N_DUT];
    logic [7:0] hold_v        [N_DUT];
    logic       hold_fb       [N_DUT];
    exp_t       exp_q[$];

    int total = 0;
    int bad   = 0;
    int edge_cnt = 0;

    rand_range_pick #(.RANGE(10), .MAX_TRIES(15)) u_dut0 (
        .clk_25M(clk), .rst_n(rst_n), .rand_num(rand_num), .req(req[0]),
        .busy(busy[0]), .valid(valid[0]), .value(value[0]), .fallback(fallback[0]));
    rand_range_pick #(.RANGE(10), .MAX_TRIES(4)) u_dut1 (
        .clk_25M(clk), .rst_n(rst_n), .rand_num(rand_num), .req(req[1]),
        .busy(busy[1]), .valid(valid[1]), .value(value[1]), .fallback(fallback[1]));
    rand_range_pick #(.RANGE(1), .MAX_TRIES(15)) u_dut2 (
        .clk_25M(clk), .rst_n(rst_n), .rand_num(rand_num), .req(req[2]),
        .busy(busy[2]), .valid(valid[2]), .value(value[2]), .fallback(fallback[2]));
    rand_range_pick #(.RANGE(256), .MAX_TRIES(15)) u_dut3 (
        .clk_25M(clk), .rst_n(rst_n), .rand_num(rand_num), .req(req[3]),
        .busy(busy[3]), .valid(valid[3]), .value(value[3]), .fallback(fallback[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Power-of-two mask covering 0..n-1.
    function automatic int mask_for(input int n);
        int p = 1;
        while (p < n) p = p * 2;
        return p - 1;
    endfunction

    // Monitor: pops the scoreboard on each valid, otherwise checks the held outputs.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst_n) begin
            for (int i = 0; i < N_DUT; i++) begin
                hold_v[i]  = 8'd0;
                hold_fb[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < N_DUT; i++) begin
                if (valid[i]) begin
                    if (exp_q.size() == 0) begin
                        check($sformatf("unexpected_valid_dut%0d", i), 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("valid_dut_idx%0d", i), i, e.idx);
                        check($sformatf("value_dut%0d", i), value[i], e.value);
                        check($sformatf("fallback_dut%0d", i), fallback[i], e.fb);
                        check($sformatf("valid_cycle_dut%0d", i), edge_cnt, e.cyc);
                        check($sformatf("busy_at_valid_dut%0d", i), busy[i], 0);
                        hold_v[i]  = e.value;
                        hold_fb[i] = e.fb;
                    end
                end else begin
                    check($sformatf("value_hold_dut%0d", i), value[i], hold_v[i]);
                    check($sformatf("fallback_hold_dut%0d", i), fallback[i], hold_fb[i]);
                end
            end
        end
    end

    // Starts and ends on a negedge. Queues the expected result, then drives req
    // and one byte per evaluation edge; noisy toggles req while the DUT is busy.
    task automatic do_request(input int idx, input byte_q_t seq_in, input bit noisy);
        byte_q_t seq;
        int      r;
        int      mt;
        int      mask;
        int      m;
        int      k;
        int      v;
        bit      fb;
        bit      nr;
        exp_t    e;
        seq  = seq_in;
        r    = ranges[idx];
        mt   = tries[idx];
        mask = mask_for(r);
        nr   = 1'b0;
`ifdef RAND_NO_REPEAT_EN
        nr   = 1'b1;
`endif
        while (seq.size() < mt) seq.push_back(8'($urandom));
        k  = 0;
        v  = 0;
        fb = 1'b0;
        for (int t = 0; t < mt; t++) begin
            m = seq[t] & mask;
            if (m < r && !(nr && model_last_ok[idx] && r > 1 && m == model_last[idx])) begin
                k = t + 1;
                v = m;
                break;
            end
        end
        if (k == 0) begin
            k  = mt;
            m  = seq[mt-1] & mask;
            v  = (m >= r) ? m - r : m;
            if (nr && model_last_ok[idx] && r > 1 && v == model_last[idx]) v = (v + 1) % r;
            fb = 1'b1;
        end
        model_last[idx]    = v;
        model_last_ok[idx] = 1'b1;
        e.idx   = idx;
        e.value = 8'(v);
        e.fb    = fb;
        e.cyc   = edge_cnt + k + 1;
        exp_q.push_back(e);

        req      = '0;
        req[idx] = 1'b1;
        rand_num = 8'($urandom);
        @(posedge clk);
        for (int t = 0; t < k; t++) begin
            @(negedge clk);
            req      = '0;
            req[idx] = noisy ? 1'($urandom) : 1'b0;
            rand_num = seq[t];
            check($sformatf("busy_in_sample_dut%0d", idx), busy[idx], 1);
            @(posedge clk);
        end
        @(negedge clk);
        req = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            rand_num = 8'($urandom);
        end
    endtask

    // Aborts a DUT0 request with a one-cycle reset pulse; no valid may follow.
    task automatic reset_mid_sample();
        req      = 4'b0001;
        rand_num = 8'd15;
        @(posedge clk);
        @(negedge clk);
        req      = '0;
        rand_num = 8'd15;
        check("busy_before_reset", busy[0], 1);
        @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_busy", busy[0], 0);
        check("abort_valid", valid[0], 0);
        check("abort_value", value[0], 0);
        check("abort_fallback", fallback[0], 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < N_DUT; i++) model_last_ok[i] = 1'b0;
        rand_num = 8'd7;
        @(negedge clk);
        idle(6);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst_n    = 1'b1;
        req      = '0;
        rand_num = 8'd0;
        for (int i = 0; i < N_DUT; i++) begin
            model_last[i]    = 0;
            model_last_ok[i] = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < N_DUT; i++) begin
            check($sformatf("reset_busy_dut%0d", i), busy[i], 0);
            check($sformatf("reset_valid_dut%0d", i), valid[i], 0);
            check($sformatf("reset_value_dut%0d", i), value[i], 0);
            check($sformatf("reset_fallback_dut%0d", i), fallback[i], 0);
        end
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // Directed cases from the picking rules.
        do_request(0, '{8'd7}, 1'b0);
        idle(2);
        do_request(0, '{8'd15, 8'd12, 8'd3}, 1'b0);
        idle(1);
        do_request(1, '{8'd13, 8'd13, 8'd13, 8'd13}, 1'b0);
        idle(1);
        do_request(1, '{8'd5}, 1'b0);
        do_request(1, '{8'd5, 8'd6}, 1'b0);
        do_request(1, '{8'd6, 8'd6, 8'd6, 8'd6}, 1'b1);
        idle(2);

        // Reset during SAMPLE, then a clean restart.
        reset_mid_sample();

        // Range extremes, back to back with the byte held at 200.
        for (int n = 0; n < 3; n++) begin
            do_request(2, '{8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200,
                            8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200}, 1'b0);
        end
        for (int n = 0; n < 3; n++) begin
            do_request(3, '{8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200,
                            8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200}, 1'b0);
        end
        idle(2);

        // Randomised requests: random target, bytes, busy-time req noise and gaps.
        for (int n = 0; n < 60; n++) begin
            byte_q_t seq;
            int      idx;
            idx = $urandom_range(0, N_DUT - 1);
            seq = {};
            for (int t = 0; t < tries[idx]; t++) begin
                if ($urandom_range(0, 1) == 1) seq.push_back(8'($urandom_range(0, 15)));
                else seq.push_back(8'($urandom));
            end
            do_request(idx, seq, 1'($urandom));
            idle($urandom_range(0, 2));
        end

        idle(4);
        check("pending_expectations", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
